// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM encoding and architectural constants.
package rv32i_pkg;

  typedef enum logic [2:0] {
    F_IDLE    = 3'd0,
    F_REQ     = 3'd1,
    F_WAIT    = 3'd2,
    F_DISCARD = 3'd3,
    F_FAULT   = 3'd4
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between fetch and decode. Head is presented
// combinationally; reads as zero while empty so idle outputs are clean.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full buffer is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the buffer synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage write; contents need no reset because head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word fetches to instruction memory, buffers
// {pc, instruction} pairs for decode, and handles redirects and misaligned targets.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; a producer keeps valid and its payload stable until that edge
// (a redirect is the only event allowed to change a pending request address).
// Memory returns exactly one imem_rsp_valid per accepted request, in order.
module inst_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2   // must be >= 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req_valid,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [31:0]  instruction_out,
  output logic [31:0]  pc_out,
  output logic         fetch_fault,
  output fetch_state_t dbg_state
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   pc;
  logic [31:0]   pc_nxt;
  logic [31:0]   req_pc;
  logic [31:0]   req_pc_nxt;
  logic          fault_nxt;
  logic          outstanding;
  logic [CW:0]   inflight;
  logic          req_fire;
  logic          push;
  logic          flush;
  logic          pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_head;

  // A request is in flight exactly while waiting for (or discarding) its response.
  assign outstanding     = (state == F_WAIT) || (state == F_DISCARD);
  assign inflight        = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding};
  // Only issue when the response is guaranteed a buffer slot.
  assign imem_req_valid  = (state == F_REQ) && (inflight < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_addr   = (state == F_REQ) ? pc : '0;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign inst_valid      = !fifo_empty;
  assign pop             = inst_valid && inst_ready;
  assign instruction_out = fifo_head[31:0];
  assign pc_out          = fifo_head[63:32];
  assign dbg_state       = state;

  // Next-state logic; a redirect overrides every other event in the same cycle.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    fault_nxt  = fetch_fault;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush     = 1'b1;
      pc_nxt    = redirect_pc;
      fault_nxt = (redirect_pc[1:0] != 2'b00);
      // A response still owed by memory must be swallowed before moving on;
      // a response arriving this very cycle is simply dropped here.
      if (req_fire || (outstanding && !imem_rsp_valid)) state_nxt = F_DISCARD;
      else if (fault_nxt)                               state_nxt = F_FAULT;
      else                                              state_nxt = F_REQ;
    end else begin
      case (state)
        F_IDLE: state_nxt = F_REQ;
        F_REQ: begin
          if (req_fire) begin
            req_pc_nxt = pc;
            pc_nxt     = pc + 32'd4;
            state_nxt  = F_WAIT;
          end
        end
        F_WAIT: begin
          if (imem_rsp_valid) begin
            push      = 1'b1;
            state_nxt = F_REQ;
          end
        end
        F_DISCARD: begin
          if (imem_rsp_valid) state_nxt = fetch_fault ? F_FAULT : F_REQ;
        end
        F_FAULT: state_nxt = F_FAULT;
        default: state_nxt = F_IDLE;
      endcase
    end
  end

  // State, fetch PC, captured request PC and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= F_IDLE;
      pc          <= RESET_PC;
      req_pc      <= '0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      req_pc      <= req_pc_nxt;
      fetch_fault <= fault_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data ({req_pc, imem_rsp_data}),
    .pop       (pop),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule
